ram_loader: RTL and testbench

- Write-side controller for the 16x8 program RAM: the initiator that drives the RAM's address, data, write_enable_n and bus_enable_n pins.
- Accepts a byte stream on a valid/ready handshake and writes bytes to addresses 0..15 in order.
- Generates timed active-low write strobes with setup and hold phases, and can read each location back to verify it.
- Sits between the program-load source (switch panel or serial front end) and the RAM, and holds the CPU off while loading.

---
 rtl/sap_pkg.sv | 18 +
 rtl/loader_phase_timer.sv | 36 +++
 rtl/ram_loader.sv | 165 ++++++++++++++++
 tb/tb_ram_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 constants and the program-RAM loader state encoding.
package sap_pkg;

    localparam int unsigned SAP_ADDR_W = 4;
    localparam int unsigned SAP_DATA_W = 8;
    localparam int unsigned TIMER_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        WRITE,
        HOLD,
        READ,
        DONE
    } loader_state_t;

endpackage

// File: rtl/loader_phase_timer.sv
// Loadable down-counter sizing the SETUP and WRITE phases; tc flags a count of zero.
module loader_phase_timer
    import sap_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/ram_loader.sv
// Write-side controller for the program RAM: streams 2^ADDR_W bytes into
// addresses 0.. in order with timed active-low strobes and optional readback.
module ram_loader
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W       = SAP_ADDR_W,
    parameter int unsigned DATA_W       = SAP_DATA_W,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned WE_CYCLES    = 2,
    parameter bit          VERIFY       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_enable_n,
    output logic              mem_bus_enable_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] error_addr
);

    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(SETUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WE_LOAD    = TIMER_W'(WE_CYCLES - 1);

    loader_state_t state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  error_addr_q, error_addr_d;
    logic               error_q, error_d;
    logic               we_n_q, we_n_d;
    logic               be_n_q, be_n_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               advance;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_tc;

    loader_phase_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_load  = 1'b0;
        timer_value = '0;
        advance     = 1'b0;
        unique case (state_q)
            IDLE:      if (start) state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (in_valid && in_ready_q) begin
                    state_d     = SETUP;
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_tc) begin
                    state_d     = WRITE;
                    timer_load  = 1'b1;
                    timer_value = WE_LOAD;
                end
            end
            WRITE:     if (timer_tc) state_d = HOLD;
            HOLD: begin
                if (VERIFY) state_d = READ;
                else        advance = 1'b1;
            end
            READ:      advance = 1'b1;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (advance) begin
            state_d = (addr_q == '1) ? DONE : WAIT_BYTE;
        end
    end

    // Strobes and handshake are decoded from the next state so the registered
    // pins line up with the state they belong to.
    always_comb begin
        addr_d       = addr_q;
        data_d       = data_q;
        error_d      = error_q;
        error_addr_d = error_addr_q;
        if (state_q == IDLE && start) begin
            addr_d       = '0;
            error_d      = 1'b0;
            error_addr_d = '0;
        end
        if (state_q == WAIT_BYTE && state_d == SETUP) begin
            data_d = in_data;
        end
        if (state_q == READ && mem_rdata != data_q) begin
            error_d = 1'b1;
            if (!error_q) error_addr_d = addr_q;
        end
        if (advance && state_d == WAIT_BYTE) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        we_n_d     = (state_d != WRITE);
        be_n_d     = (state_d != READ);
        in_ready_d = (state_d == WAIT_BYTE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            data_q       <= '0;
            error_q      <= 1'b0;
            error_addr_q <= '0;
            we_n_q       <= 1'b1;
            be_n_q       <= 1'b1;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            error_q      <= error_d;
            error_addr_q <= error_addr_d;
            we_n_q       <= we_n_d;
            be_n_q       <= be_n_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_address        = addr_q;
    assign mem_data           = data_q;
    assign mem_write_enable_n = we_n_q;
    assign mem_bus_enable_n   = be_n_q;
    assign in_ready           = in_ready_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign error_addr         = error_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a VERIFY=1 instance with a RAM model and write
// scoreboard, plus a VERIFY=0 instance for the no-readback build.
module tb_ram_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned N  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start, in_valid, in_ready, we_n, be_n, busy, done, error;
    logic [DW-1:0] in_data, mem_data, mem_rdata;
    logic [AW-1:0] mem_address, error_addr;

    logic          nv_start, nv_in_valid, nv_in_ready, nv_we_n, nv_be_n, nv_busy, nv_done, nv_error;
    logic [DW-1:0] nv_in_data, nv_mem_data, nv_mem_rdata;
    logic [AW-1:0] nv_mem_address, nv_error_addr;

    ram_loader #(
        .ADDR_W(AW), .DATA_W(DW), .SETUP_CYCLES(1), .WE_CYCLES(2), .VERIFY(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_address(mem_address), .mem_data(mem_data),
        .mem_write_enable_n(we_n), .mem_bus_enable_n(be_n), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .error(error), .error_addr(error_addr)
    );

    ram_loader #(
        .ADDR_W(AW), .DATA_W(DW), .SETUP_CYCLES(1), .WE_CYCLES(2), .VERIFY(1'b0)
    ) dut_nv (
        .clk(clk), .reset(reset), .start(nv_start), .in_data(nv_in_data), .in_valid(nv_in_valid),
        .in_ready(nv_in_ready), .mem_address(nv_mem_address), .mem_data(nv_mem_data),
        .mem_write_enable_n(nv_we_n), .mem_bus_enable_n(nv_be_n), .mem_rdata(nv_mem_rdata),
        .busy(nv_busy), .done(nv_done), .error(nv_error), .error_addr(nv_error_addr)
    );

    logic [DW-1:0] ram [N];
    logic [DW-1:0] nv_ram [N];
    logic          inject;

    always @(posedge clk) begin
        if (we_n === 1'b0) ram[mem_address] <= mem_data;
        if (nv_we_n === 1'b0) nv_ram[nv_mem_address] <= nv_mem_data;
    end

    assign mem_rdata    = (inject && (mem_address == 4'd3 || mem_address == 4'd9)) ? 8'hFF : ram[mem_address];
    assign nv_mem_rdata = nv_ram[nv_mem_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t sb[$];
    wr_t exp_w;

    logic [DW-1:0] exp_ram [N];
    logic [DW-1:0] nv_exp_ram [N];
    int exp_addr  = 0;
    int nv_addr   = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe-shape monitor and write scoreboard.
    logic          we_prev  = 1'b1;
    logic          we_prev2 = 1'b1;
    logic          be_prev  = 1'b1;
    logic [AW-1:0] addr_prev;
    logic [DW-1:0] data_prev;
    int            low_len  = 0;

    always @(negedge clk) begin
        if (reset) begin
            we_prev  = 1'b1;
            we_prev2 = 1'b1;
            be_prev  = 1'b1;
            low_len  = 0;
        end else begin
            check("strobe_overlap", we_n | be_n, 1);
            if (we_n === 1'b0 || we_prev === 1'b0) begin
                check("addr_stable", mem_address, addr_prev);
                check("data_stable", mem_data, data_prev);
            end
            if (we_n === 1'b0 && we_prev === 1'b1) begin
                low_len = 1;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    check("wr_addr", mem_address, exp_w.a);
                    check("wr_data", mem_data, exp_w.d);
                end
            end else if (we_n === 1'b0) begin
                low_len++;
            end
            if (we_n === 1'b1 && we_prev === 1'b0) check("we_low_cycles", low_len, 2);
            if (be_n === 1'b0) check("be_only_in_read", {we_prev2, we_prev, be_prev}, 3'b011);
            check("nv_be_n_high", nv_be_n, 1);
            we_prev2 = we_prev;
            we_prev  = we_n;
            be_prev  = be_n;
        end
        addr_prev = mem_address;
        data_prev = mem_data;
    end

    task automatic check_reset(input string tag);
        check({tag, "_we_n"}, we_n, 1);
        check({tag, "_be_n"}, be_n, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_error_addr"}, error_addr, 0);
        check({tag, "_address"}, mem_address, 0);
        check({tag, "_data"}, mem_data, 0);
    endtask

    task automatic pulse_start(input bit nv);
        if (nv) nv_start = 1'b1;
        else    start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        nv_start = 1'b0;
        start    = 1'b0;
        if (nv) nv_addr = 0;
        else    exp_addr = 0;
        check("busy_after_start", nv ? nv_busy : busy, 1);
        check("error_cleared", nv ? nv_error : error, 0);
        check("in_ready_after_start", nv ? nv_in_ready : in_ready, 1);
    endtask

    // Presents one byte, waits (bounded) for acceptance and records the expectation.
    task automatic send(input bit nv, input logic [DW-1:0] b, output int rdy_c, output int acc_c);
        int  n;
        wr_t w;
        if (nv) begin nv_in_data = b; nv_in_valid = 1'b1; end
        else    begin in_data = b;    in_valid = 1'b1;    end
        n = 0;
        while (!(nv ? nv_in_ready : in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", nv ? nv_in_ready : in_ready, 1);
        rdy_c = cyc;
        @(posedge clk);
        if (nv) begin
            nv_exp_ram[nv_addr] = b;
            nv_addr++;
        end else begin
            w.a = AW'(exp_addr);
            w.d = b;
            sb.push_back(w);
            exp_ram[exp_addr] = b;
            exp_addr++;
        end
        @(negedge clk);
        acc_c = cyc;
    endtask

    task automatic load(input bit nv, input logic [DW-1:0] base, input int stall_at,
                        input int mid_start_at, input int lat_exp);
        int rdy_c, acc_c, prev_acc, n;
        prev_acc = 0;
        pulse_start(nv);
        for (int i = 0; i < int'(N); i++) begin
            if (i == stall_at) begin
                n = 0;
                while (!in_ready && n < 50) begin @(negedge clk); n++; end
                for (int k = 0; k < 10; k++) begin
                    check("stall_in_ready", in_ready, 1);
                    check("stall_address", mem_address, stall_at);
                    check("stall_no_strobe", we_n, 1);
                    @(negedge clk);
                end
            end
            if (nv && i == mid_start_at) begin
                nv_in_data = base + 8'(i);
                nv_start   = 1'b1;
                @(negedge clk);
                nv_start = 1'b0;
                check("mid_start_address", nv_mem_address, i - 1);
                check("mid_start_busy", nv_busy, 1);
            end
            send(nv, base + 8'(i), rdy_c, acc_c);
            if (i > 0 && i != stall_at) check("in_ready_latency", rdy_c - prev_acc, lat_exp);
            prev_acc = acc_c;
            if (i + 1 == stall_at) in_valid = 1'b0;
        end
        in_valid    = 1'b0;
        nv_in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit nv, input int exp_cycles);
        int n;
        n = 0;
        while (!(nv ? nv_done : done) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", nv ? nv_done : done, 1);
        check("done_cycle", cyc - start_cyc, exp_cycles);
        @(negedge clk);
        check("done_one_cycle", nv ? nv_done : done, 0);
        check("busy_after_done", nv ? nv_busy : busy, 0);
    endtask

    task automatic check_ram(input bit nv);
        for (int i = 0; i < int'(N); i++) begin
            if (nv) check("nv_ram_content", nv_ram[i], nv_exp_ram[i]);
            else    check("ram_content", ram[i], exp_ram[i]);
        end
    endtask

    initial begin
        int n, rdy_c, acc_c;
        reset       = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        nv_start    = 1'b0;
        nv_in_valid = 1'b0;
        nv_in_data  = '0;
        inject      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back load of 0x10..0x1F: 1 + 16*6 cycles to the done pulse.
        load(1'b0, 8'h10, -1, -1, 5);
        wait_done(1'b0, 97);
        check("clean_error", error, 0);
        check("clean_error_addr", error_addr, 0);
        check("clean_sb_drained", sb.size(), 0);
        check_ram(1'b0);

        // Stall before byte 5 plus bad readback at 3 and 9.
        inject = 1'b1;
        load(1'b0, 8'hA0, 5, -1, 5);
        wait_done(1'b0, 107);
        check("fault_error", error, 1);
        check("fault_error_addr", error_addr, 3);
        check("fault_sb_drained", sb.size(), 0);
        check_ram(1'b0);
        inject = 1'b0;

        // Reset in the first WRITE cycle of address 7.
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) send(1'b0, 8'h30 + 8'(i), rdy_c, acc_c);
        in_valid = 1'b0;
        n = 0;
        while (we_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("strobe_at_7", we_n, 0);
        check("strobe_addr_7", mem_address, 7);
        reset = 1'b1;
        #1;
        check_reset("async");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load(1'b0, 8'h50, -1, -1, 5);
        wait_done(1'b0, 97);
        check("restart_error", error, 0);
        check("restart_sb_drained", sb.size(), 0);
        check_ram(1'b0);

        // VERIFY=0 build with a start pulse in the middle of the load.
        load(1'b1, 8'h60, -1, 8, 4);
        wait_done(1'b1, 81);
        check("nv_error", nv_error, 0);
        check_ram(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
